mul_rr_sched: RTL and testbench
===============================

# mul_rr_sched

Round-robin scheduler that shares one signed 32x32 combinational multiplier (`samul_v1`) among `N_REQ` requesters. It accepts one operand pair at a time and registers operands in front of the multiplier. It allows `MUL_CYCLES` settle cycles as a multicycle path, then registers the 64-bit product. It returns the product with the requester's index under a valid/ready handshake. It sits between the datapath's issue ports and the multiplier.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 32: operand width. Fixed by `samul_v1`.
- `MUL_CYCLES`, default 2: settle cycles allowed for the combinational multiplier, 1..15.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  N_REQ: per-requester operand valid.
- `req_a`  in  N_REQ*WIDTH: packed multiplicand operands, signed; slice i belongs to requester i.
- `req_b`  in  N_REQ*WIDTH: packed multiplier operands, signed.
- `req_ready`  out  N_REQ: one-hot or zero. High for the granted requester in the accept cycle.
- `rsp_valid`  out  1: product available.
- `rsp_ready`  in  1: consumer accepts the product.
- `rsp_id`  out  clog2(N_REQ): index of the requester that owns `rsp_result`.
- `rsp_result`  out  2*WIDTH: signed product.
- `busy`  out  1: state is not IDLE.

## Operation
- FSM states:
  - IDLE -> BUSY on handshake.
  - BUSY -> DONE when the settle counter reaches `MUL_CYCLES`-1.
  - DONE -> IDLE on `rsp_ready`.
- Arbitration is only in IDLE:
  - Search `req_valid` starting from pointer `ptr` and wrapping modulo `N_REQ`.
  - The first set bit, g, gets `req_ready[g]`=1. This is combinational from `req_valid` and `ptr`.
  - Handshake = `req_valid[g]` & `req_ready[g]`. On handshake: capture `req_a[g]`, `req_b[g]` and g; set `ptr` to (g+1) mod `N_REQ`; clear the counter.
- In BUSY and DONE, `req_ready` is all zero. Requesters must hold `req_valid` and operands until they see `req_ready`.
- The operand registers feed `samul_v1` directly. The counter increments each BUSY cycle.
- On the last BUSY cycle, `rsp_result` and `rsp_id` are registered from the multiplier output and the captured index.
- In DONE, `rsp_valid`=1. `rsp_result` and `rsp_id` stay stable until `rsp_ready`.
- Arithmetic is full-precision two's complement. There is no truncation or saturation: (-2^31)*(-2^31) = 0x4000_0000_0000_0000.
- Operand registers do not change outside the accept cycle, which keeps the multicycle path stable.
- Reset, asynchronous and valid at any point including mid-operation:
  - State returns to IDLE, `ptr`=0, counter=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `busy`=0, operand registers=0.
  - Any in-flight product is discarded; no response is issued for it.

## Timing
- Accept at cycle T. BUSY covers T+1 .. T+`MUL_CYCLES`. `rsp_valid` rises at T+`MUL_CYCLES`+1.
- If `rsp_ready` is high in the first DONE cycle, the next accept is possible at T+`MUL_CYCLES`+2. Peak throughput is one product per `MUL_CYCLES`+2 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. The others wait, and every requester is served within `N_REQ` grants.
- With no `req_valid` bits set, the block stays in IDLE and `ptr` is unchanged.
- `rsp_ready` low in DONE: stall indefinitely with outputs stable and no new grants.
- Place a multicycle constraint of `MUL_CYCLES` from the operand registers to the result register.

## Structure
- Package `mul_sched_pkg`: state enum {IDLE, BUSY, DONE}, default `N_REQ`/`WIDTH`/`MUL_CYCLES` constants, and the id-width function.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are request vector and `ptr`; outputs are one-hot grant, index and any-valid.
- Top level holds: FSM, counter, operand and result registers, and one `samul_v1` instance.

## Test plan
- **Single request.** Requester 2 sends a=7, b=-3. Required: `rsp_valid` at T+`MUL_CYCLES`+1, `rsp_id`=2, `rsp_result`=0xFFFF_FFFF_FFFF_FFEB.
- **Fairness.** All four requesters are held valid from reset. Required: grant order 0,1,2,3,0. Each `req_ready` is a single-cycle pulse.
- **Sign corners.** (-2^31)*(-2^31) -> 0x4000_0000_0000_0000. (-2^31)*1 -> 0xFFFF_FFFF_8000_0000. 0*(-1) -> 0.
- **Back-pressure.** Hold `rsp_ready`=0 for 10 cycles in DONE with requester 1 valid. Required: result stable, `req_ready`=0 throughout; requester 1 is granted the cycle after `rsp_ready` rises.
- **Reset mid-BUSY.** Assert `rst` one cycle after accept. Required: all outputs zero at once, no `rsp_valid` for that operation, and the first grant after reset goes to the lowest valid index.
- **Pointer wrap.** Grant requester 3 with only requesters 0 and 3 valid. Required: the next grant goes to 0.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared types, default sizes and helpers for the round-robin multiplier scheduler.
package mul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_REQ_DEF      = 4;
    localparam int WIDTH_DEF      = 32;
    localparam int MUL_CYCLES_DEF = 2;

    // Settle counter width: covers MUL_CYCLES up to 15.
    localparam int CNT_W = 4;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_pick
    import mul_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDW   = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDW-1:0]   o_idx,
    output logic             o_any
);

    int w_pos;

    // Walk positions ptr, ptr+1, ... modulo N_REQ and keep the first requester found.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
            if (!o_any && i_req[w_pos]) begin
                o_any        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/samul_v1.sv
// Signed full-precision combinational multiplier shared by the scheduler.
module samul_v1 #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0]   i_a,
    input  logic signed [WIDTH-1:0]   i_b,
    output logic signed [2*WIDTH-1:0] o_p
);

    // Full two's-complement product, no truncation.
    always_comb begin
        o_p = i_a * i_b;
    end

endmodule

// File: rtl/mul_rr_sched.sv
// Round-robin scheduler sharing one signed multiplier among N_REQ requesters.
// The path r_a/r_b -> samul_v1 -> r_result is a MUL_CYCLES multicycle path;
// operand registers only change in the accept cycle so it stays stable.
module mul_rr_sched
    import mul_sched_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [id_w(N_REQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     busy
);

    localparam int IDW = id_w(N_REQ);

    state_t                      r_state;
    logic [IDW-1:0]              r_ptr;
    logic [IDW-1:0]              r_id;
    logic [CNT_W-1:0]            r_cnt;
    logic signed [WIDTH-1:0]     r_a;
    logic signed [WIDTH-1:0]     r_b;
    logic signed [2*WIDTH-1:0]   r_result;
    logic [IDW-1:0]              r_rsp_id;

    logic [N_REQ-1:0]            w_gnt;
    logic [IDW-1:0]              w_idx;
    logic                        w_any;
    logic                        w_hs;
    logic signed [2*WIDTH-1:0]   w_prod;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    samul_v1 #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    // Grants exist only in IDLE and are suppressed while reset is asserted.
    always_comb begin
        req_ready  = (r_state == IDLE && !rst) ? w_gnt : '0;
        w_hs       = (r_state == IDLE) && w_any;
        rsp_valid  = (r_state == DONE);
        busy       = (r_state != IDLE);
        rsp_id     = r_rsp_id;
        rsp_result = r_result;
    end

    // Scheduler FSM with settle counter, operand capture and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_id     <= '0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_rsp_id <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_a     <= req_a[w_idx*WIDTH +: WIDTH];
                        r_b     <= req_b[w_idx*WIDTH +: WIDTH];
                        r_id    <= w_idx;
                        r_ptr   <= (w_idx == IDW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(MUL_CYCLES - 1)) begin
                        r_result <= w_prod;
                        r_rsp_id <= r_id;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_rr_sched.sv
// Bench for mul_rr_sched: directed scenarios plus randomized traffic against a
// transaction-level round-robin / signed-product reference model.
module tb_mul_rr_sched;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [2*W-1:0]   rsp_result;
    logic             busy;

    logic [W-1:0]     op_a [N];
    logic [W-1:0]     op_b [N];

    int               n_cmp  = 0;
    int               n_fail = 0;
    int               m_ptr  = 0;

    logic [N-1:0]     mask;
    logic [N-1:0]     left;
    logic [63:0]      res;

    mul_rr_sched #(
        .N_REQ      (N),
        .WIDTH      (W),
        .MUL_CYCLES (MC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first valid requester at or after the model pointer.
    function automatic int pick(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"},  64'(req_ready),  64'd0);
        chk({tag, "_vld"},  64'(rsp_valid),  64'd0);
        chk({tag, "_id"},   64'(rsp_id),     64'd0);
        chk({tag, "_res"},  rsp_result,      64'd0);
        chk({tag, "_busy"}, 64'(busy),       64'd0);
    endtask

    // One full transaction from an IDLE cycle; entered and left 1 time unit after a rising edge.
    task automatic serve(input logic [N-1:0] m, input int stall, input bit keep,
                         output logic [N-1:0] rem, output logic [63:0] got);
        int          g;
        longint      pa;
        longint      pb;
        logic [63:0] expv;
        req_valid = m;
        g = pick(m);
        @(negedge clk);
        chk("grant", 64'(req_ready), 64'(onehot(g)));
        chk("idle_busy", 64'(busy), 64'd0);
        pa   = longint'($signed(op_a[g]));
        pb   = longint'($signed(op_b[g]));
        expv = 64'(pa * pb);
        @(posedge clk); #1;
        m_ptr = (g + 1) % N;
        if (!keep) req_valid[g] = 1'b0;
        rem = req_valid;
        repeat (MC) begin
            @(negedge clk);
            chk("busy_vld", 64'(rsp_valid), 64'd0);
            chk("busy_rdy", 64'(req_ready), 64'd0);
            chk("busy_flag", 64'(busy), 64'd1);
            @(posedge clk); #1;
        end
        repeat (stall) begin
            @(negedge clk);
            chk("stall_vld", 64'(rsp_valid), 64'd1);
            chk("stall_res", rsp_result, expv);
            chk("stall_id", 64'(rsp_id), 64'(g));
            chk("stall_rdy", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_vld", 64'(rsp_valid), 64'd1);
        chk("rsp_id", 64'(rsp_id), 64'(g));
        chk("rsp_res", rsp_result, expv);
        got = rsp_result;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("idle");
        @(posedge clk); #1;

        // Single request from requester 2: 7 * -3.
        op_a[2] = 32'd7;
        op_b[2] = 32'hFFFF_FFFD;
        serve(4'b0100, 0, 1'b0, left, res);
        chk("single_res", res, 64'hFFFF_FFFF_FFFF_FFEB);

        // Pointer wrap: pointer sits at 3, requesters 0 and 3 valid.
        op_a[0] = $urandom; op_b[0] = $urandom;
        op_a[3] = $urandom; op_b[3] = $urandom;
        serve(4'b1001, 0, 1'b0, left, res);
        serve(left, 0, 1'b0, left, res);

        // Sign corners through requester 1.
        op_a[1] = 32'h8000_0000; op_b[1] = 32'h8000_0000;
        serve(4'b0010, 0, 1'b0, left, res);
        chk("corner_mm", res, 64'h4000_0000_0000_0000);
        op_a[1] = 32'h8000_0000; op_b[1] = 32'd1;
        serve(4'b0010, 0, 1'b0, left, res);
        chk("corner_m1", res, 64'hFFFF_FFFF_8000_0000);
        op_a[1] = 32'd0; op_b[1] = 32'hFFFF_FFFF;
        serve(4'b0010, 0, 1'b0, left, res);
        chk("corner_zero", res, 64'd0);

        // Back-pressure: requester 2 served with 10 stalled DONE cycles while 1 waits.
        op_a[1] = $urandom; op_b[1] = $urandom;
        op_a[2] = $urandom; op_b[2] = $urandom;
        serve(4'b0110, 10, 1'b0, left, res);
        serve(left, 0, 1'b0, left, res);

        // Fairness: all requesters held valid from reset.
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
        end
        req_valid = 4'b1111;
        @(posedge clk); #1;
        chk_zero("rst_fair");
        rst   = 1'b0;
        m_ptr = 0;
        repeat (5) serve(4'b1111, 0, 1'b1, left, res);

        // Reset in the middle of BUSY discards the operation.
        req_valid = 4'b1100;
        @(negedge clk);
        chk("mid_grant", 64'(req_ready), 64'(onehot(pick(4'b1100))));
        @(posedge clk); #1;
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk_zero("mid_rst");
        @(posedge clk); #1;
        rst   = 1'b0;
        m_ptr = 0;
        serve(4'b1100, 0, 1'b0, left, res);
        serve(left, 0, 1'b0, left, res);

        // Randomized traffic with random back-pressure.
        mask = '0;
        for (int it = 0; it < 30; it++) begin
            if (mask == '0) begin
                for (int i = 0; i < N; i++) begin
                    op_a[i] = $urandom;
                    op_b[i] = $urandom;
                end
                mask = 4'($urandom_range(1, 15));
            end
            serve(mask, int'($urandom_range(0, 3)), 1'b0, left, res);
            mask = left;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
